// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader.
// FSM state encoding and the length-field width.
package imem_loader_pkg;

   localparam int LEN_W = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_CSUM   = 3'd5,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_e;

   function automatic logic is_rx(input state_e s);
      return (s == S_LEN_HI) || (s == S_LEN_LO) ||
             (s == S_DATA)   || (s == S_CSUM);
   endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Byte-to-word packer: MSB-first shift register plus byte counter.
// word_ready flags that the byte being shifted completes a word.
module imem_word_packer
   import imem_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  shift_en,
   input  logic [7:0]            din,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_ready
);

   localparam int BPW = DATA_WIDTH / 8;
   localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   assign word_ready = shift_en && (cnt_q == CW'(BPW - 1));
   assign word       = word_q;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clear) begin
         word_d = '0;
         cnt_d  = '0;
      end else if (shift_en) begin
         word_d = (word_q << 8) | DATA_WIDTH'(din);
         cnt_d  = word_ready ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed byte image into IMEM
// and holds the CPU in reset until a load completes cleanly.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  cpu_rst,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned CAP = 2 ** ADDR_WIDTH;

   state_e                state_q, state_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [LEN_W-1:0]      wcnt_q, wcnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            csum_q, csum_d;
   logic [LEN_W-1:0]      n_len;
   logic                  accept;
   logic                  pk_clear;
   logic                  pk_shift;
   logic                  pk_ready;
   logic [DATA_WIDTH-1:0] pk_word;

   assign in_ready   = is_rx(state_q);
   assign accept     = in_valid && in_ready;
   assign n_len      = {len_q[LEN_W-1:8], in_data};
   assign imem_we    = (state_q == S_WRITE);
   assign imem_addr  = addr_q;
   assign imem_wdata = pk_word;
   assign busy       = is_rx(state_q) || (state_q == S_WRITE);
   assign done       = (state_q == S_DONE);
   assign err        = (state_q == S_ERR);
   // A start in DONE re-holds the CPU in the very cycle it is seen.
   assign cpu_rst    = (state_q != S_DONE) || start;

   imem_word_packer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (pk_clear),
      .shift_en  (pk_shift),
      .din       (in_data),
      .word      (pk_word),
      .word_ready(pk_ready)
   );

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      wcnt_d   = wcnt_q;
      addr_d   = addr_q;
      csum_d   = csum_q;
      pk_clear = 1'b0;
      pk_shift = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d  = S_LEN_HI;
               len_d    = '0;
               wcnt_d   = '0;
               addr_d   = '0;
               csum_d   = '0;
               pk_clear = 1'b1;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               len_d   = {in_data, 8'h00};
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d = n_len;
               if (n_len == '0)
                  state_d = S_CSUM;
               else if (32'(n_len) > CAP)
                  state_d = S_ERR;
               else
                  state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               csum_d   = csum_q ^ in_data;
               pk_shift = 1'b1;
               if (pk_ready)
                  state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            wcnt_d = wcnt_q + LEN_W'(1);
            if (wcnt_d == len_q)
               state_d = S_CSUM;
            else
               state_d = S_DATA;
         end
         S_CSUM: begin
            if (accept)
               state_d = (in_data == csum_q) ? S_DONE : S_ERR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         wcnt_q  <= '0;
         addr_q  <= '0;
         csum_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         csum_q  <= csum_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader with a stream-level
// reference model and an IMEM write scoreboard.
module tb_imem_loader;

   localparam int AW  = 9;
   localparam int DW  = 32;
   localparam int CAP = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_wdata;
   logic          cpu_rst;
   logic          busy;
   logic          done;
   logic          err;

   imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_rst   (cpu_rst),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int            n_chk  = 0;
   int            n_fail = 0;
   int            we_cnt = 0;
   int            rdy_bad = 0;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] mem [CAP];
   logic [DW-1:0] words_q [$];
   logic [7:0]    stream_q [$];
   logic [7:0]    model_csum;

   always @(posedge clk) begin
      if (imem_we && !rst) begin
         mem[imem_addr] = imem_wdata;
         last_addr = imem_addr;
         we_cnt++;
         if (in_ready) rdy_bad++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic rand_words(input int n);
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
   endtask

   // Stream = big-endian count, MSB-first payload, XOR checksum.
   task automatic build_stream(input int n);
      stream_q.delete();
      model_csum = 8'h00;
      stream_q.push_back(8'((n >> 8) & 'hff));
      stream_q.push_back(8'(n & 'hff));
      for (int i = 0; i < n; i++)
         for (int b = DW / 8 - 1; b >= 0; b--) begin
            stream_q.push_back(8'((words_q[i] >> (8 * b)) & 'hff));
            model_csum ^= 8'((words_q[i] >> (8 * b)) & 'hff);
         end
      stream_q.push_back(model_csum);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int  k;
      logic ok;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         tick();
      end
      in_valid = 1'b1;
      in_data  = b;
      k = 0;
      ok = 1'b0;
      while (!ok && k < 60) begin
         ok = in_ready;
         tick();
         k++;
      end
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic send_range(input int lo, input int hi, input int gmax);
      for (int i = lo; i < hi; i++)
         send_byte(stream_q[i], (gmax > 0) ? $urandom_range(gmax, 0) : 0);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 300) begin
         tick();
         k++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < CAP; i++) mem[i] = 'x;
   endtask

   task automatic check_load(input string tag, input int n,
                             input int we0, input int rb0, input bit good);
      int bad = 0;
      for (int i = 0; i < n; i++)
         if (mem[i] !== words_q[i]) bad++;
      chk({tag, "_words"}, bad, 0);
      chk({tag, "_we_cnt"}, we_cnt - we0, n);
      chk({tag, "_rdy_in_write"}, rdy_bad - rb0, 0);
      chk({tag, "_done"}, done, good);
      chk({tag, "_err"}, err, !good);
      chk({tag, "_cpu_rst"}, cpu_rst, !good);
   endtask

   task automatic run_load(input string tag, input int n,
                           input bit ovr, input logic [7:0] ovr_cs,
                           input int gmax);
      int we0, rb0;
      bit good;
      clear_mem();
      we0 = we_cnt;
      rb0 = rdy_bad;
      build_stream(n);
      if (ovr) stream_q[stream_q.size() - 1] = ovr_cs;
      good = (stream_q[stream_q.size() - 1] == model_csum);
      pulse_start();
      chk({tag, "_busy_after_start"}, busy, 1);
      send_range(0, stream_q.size(), gmax);
      wait_idle();
      check_load(tag, n, we0, rb0, good);
   endtask

   initial begin
      int we0, rb0;
      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_we", imem_we, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      tick();

      words_q = '{32'h11223344, 32'hAABBCCDD};
      run_load("t1", 2, 1'b0, 8'h00, 0);
      chk("t1_mem0", mem[0], 32'h11223344);
      chk("t1_mem1", mem[1], 32'hAABBCCDD);

      run_load("t2", 2, 1'b1, 8'h01, 0);
      chk("t2_mem1_kept", mem[1], 32'hAABBCCDD);

      words_q.delete();
      run_load("t3_empty", 0, 1'b0, 8'h00, 0);

      we0 = we_cnt;
      pulse_start();
      stream_q = '{8'h02, 8'h01};
      send_range(0, 2, 0);
      chk("t3_big_err", err, 1);
      chk("t3_big_done", done, 0);
      chk("t3_big_busy", busy, 0);
      chk("t3_big_cpu_rst", cpu_rst, 1);
      chk("t3_big_we", we_cnt - we0, 0);

      rand_words(16);
      run_load("t4_gaps", 16, 1'b0, 8'h00, 5);

      rand_words(4);
      build_stream(4);
      pulse_start();
      send_range(0, 8, 0);
      rst = 1'b1;
      tick();
      chk("t5_in_ready", in_ready, 0);
      chk("t5_we", imem_we, 0);
      chk("t5_addr", imem_addr, 0);
      chk("t5_wdata", imem_wdata, 0);
      chk("t5_cpu_rst", cpu_rst, 1);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_err", err, 0);
      rst = 1'b0;
      tick();
      rand_words(8);
      run_load("t5_reload", 8, 1'b0, 8'h00, 2);

      rand_words(4);
      build_stream(4);
      clear_mem();
      we0 = we_cnt;
      rb0 = rdy_bad;
      pulse_start();
      send_range(0, 7, 0);
      pulse_start();
      chk("t6_busy_after_start", busy, 1);
      send_range(7, stream_q.size(), 0);
      wait_idle();
      check_load("t6_ign", 4, we0, rb0, 1'b1);

      rand_words(CAP);
      run_load("t6_full", CAP, 1'b0, 8'h00, 0);
      chk("t6_last_addr", last_addr, CAP - 1);

      pulse_start();
      chk("t6_restart_cpu_rst", cpu_rst, 1);
      chk("t6_restart_done", done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
